bf16_unpack: RTL and testbench

BF16_UNPACK -- requirements
Module: bf16_unpack

---
 rtl/bf16_pkg.sv | 26 ++
 rtl/lzc7.sv | 16 +
 rtl/bf16_unpack.sv | 137 +++++++++++++
 tb/tb_bf16_unpack.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions used by both the unpacker and the packer side.
package bf16_pkg;

    localparam int unsigned BIAS   = 127;
    localparam int unsigned EXP_W  = 9;
    localparam int unsigned MANT_W = 8;

    typedef enum logic [2:0] {
        ClsZero = 3'd0,
        ClsSub  = 3'd1,
        ClsNorm = 3'd2,
        ClsInf  = 3'd3,
        ClsNan  = 3'd4
    } bf16_class_e;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StHold
    } unpack_state_e;

    function automatic logic [EXP_W-1:0] unbias(input logic [7:0] e);
        return EXP_W'({1'b0, e}) - EXP_W'(BIAS);
    endfunction

endpackage

// File: rtl/lzc7.sv
// Combinational leading-one locator for a 7-bit fraction: position k and shift 7-k.
module lzc7 (
    input  logic [6:0] frac_i,
    output logic [2:0] pos_o,
    output logic [2:0] shamt_o
);

    always_comb begin
        pos_o = '0;
        for (int i = 0; i < 7; i++) begin
            if (frac_i[i]) pos_o = 3'(i);
        end
        shamt_o = 3'd7 - pos_o;
    end

endmodule

// File: rtl/bf16_unpack.sv
// Unpacks a bfloat16 operand into sign, unbiased exponent, explicit 1.7 significand and class,
// normalizing subnormals over several cycles.
module bf16_unpack
    import bf16_pkg::*;
#(
    parameter int unsigned SHIFT_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic [2:0]        out_class
);

    localparam logic [2:0]       StepMax    = 3'(SHIFT_PER_CYCLE);
    // Subnormal exponent is -126-(7-k) = -133+k.
    localparam logic [EXP_W-1:0] SubExpBase = EXP_W'(-int'(BIAS) - 6);
    localparam logic [EXP_W-1:0] SpecialExp = EXP_W'(BIAS + 1);

    unpack_state_e     state_q, state_d;
    logic              valid_q, valid_d;
    logic              sign_q, sign_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    bf16_class_e       class_q, class_d;
    logic [2:0]        cnt_q, cnt_d;

    logic       accept;
    logic [2:0] step;
    logic [2:0] lz_pos;
    logic [2:0] lz_shamt;
    logic [7:0] in_exp;
    logic [6:0] in_frac;

    assign in_exp  = in_data[14:7];
    assign in_frac = in_data[6:0];

    lzc7 u_lzc7 (
        .frac_i  (in_frac),
        .pos_o   (lz_pos),
        .shamt_o (lz_shamt)
    );

    assign in_ready = (state_q == StIdle) || ((state_q == StHold) && out_ready);
    assign accept   = in_valid && in_ready;
    assign step     = (cnt_q > StepMax) ? StepMax : cnt_q;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        class_d = class_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: ;
            StNorm: begin
                mant_d = mant_q << step;
                cnt_d  = cnt_q - step;
                if (cnt_d == 3'd0) begin
                    state_d = StHold;
                    valid_d = 1'b1;
                end
            end
            StHold: begin
                if (out_ready && !in_valid) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new operand overrides whatever the hold/idle path decided above.
        if (accept) begin
            sign_d  = in_data[15];
            cnt_d   = 3'd0;
            state_d = StHold;
            valid_d = 1'b1;
            if (in_exp == 8'd0 && in_frac == 7'd0) begin
                exp_d   = '0;
                mant_d  = '0;
                class_d = ClsZero;
            end else if (in_exp == 8'd0) begin
                exp_d   = SubExpBase + EXP_W'(lz_pos);
                mant_d  = {1'b0, in_frac};
                class_d = ClsSub;
                cnt_d   = lz_shamt;
                state_d = StNorm;
                valid_d = 1'b0;
            end else if (in_exp == 8'hFF) begin
                exp_d   = SpecialExp;
                mant_d  = {1'b1, in_frac};
                class_d = (in_frac == 7'd0) ? ClsInf : ClsNan;
            end else begin
                exp_d   = unbias(in_exp);
                mant_d  = {1'b1, in_frac};
                class_d = ClsNorm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            class_q <= ClsZero;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            class_q <= class_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sign  = sign_q;
    assign out_exp   = exp_q;
    assign out_mant  = mant_q;
    assign out_class = class_q;

endmodule

// File: tb/tb_bf16_unpack.sv
// Scoreboard bench for bf16_unpack: two instances (1 and 4 shifts per cycle) share clock and reset.
module tb_bf16_unpack;

    typedef struct packed {
        logic       sign;
        logic [8:0] exp;
        logic [7:0] mant;
        logic [2:0] cls;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        out_ready;

    logic       in_valid1, in_ready1, out_valid1, out_sign1;
    logic [8:0] out_exp1;
    logic [7:0] out_mant1;
    logic [2:0] out_class1;

    logic       in_valid4, in_ready4, out_valid4, out_sign4;
    logic [8:0] out_exp4;
    logic [7:0] out_mant4;
    logic [2:0] out_class4;

    res_t q1[$];
    res_t q4[$];
    int   pop_cyc[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bf16_unpack #(.SHIFT_PER_CYCLE(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_sign  (out_sign1),
        .out_exp   (out_exp1),
        .out_mant  (out_mant1),
        .out_class (out_class1)
    );

    bf16_unpack #(.SHIFT_PER_CYCLE(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_sign  (out_sign4),
        .out_exp   (out_exp4),
        .out_mant  (out_mant4),
        .out_class (out_class4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitors: compare every transfer against the head of the matching queue.
    always @(negedge clk) begin
        res_t a;
        if (rst_n && out_valid1 && out_ready) begin
            a = '{out_sign1, out_exp1, out_mant1, out_class1};
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut1_unexpected_output: got %h, expected no output", a);
            end else begin
                check("dut1_result", 32'(a), 32'(q1.pop_front()));
                pop_cyc.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        res_t a;
        if (rst_n && out_valid4 && out_ready) begin
            a = '{out_sign4, out_exp4, out_mant4, out_class4};
            if (q4.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut4_unexpected_output: got %h, expected no output", a);
            end else begin
                check("dut4_result", 32'(a), 32'(q4.pop_front()));
            end
        end
    end

    // Called just after a rising edge; returns 1 time unit after the accepting edge.
    task automatic send(input int sel, input logic [15:0] d, input res_t e);
        int t;
        t = 0;
        in_data = d;
        if (sel == 1) in_valid1 = 1'b1;
        else          in_valid4 = 1'b1;
        @(negedge clk);
        while (!((sel == 1) ? in_ready1 : in_ready4) && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        if (t >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready low for 50 cycles, expected accept of %h", d);
        end else if (sel == 1) begin
            q1.push_back(e);
        end else begin
            q4.push_back(e);
        end
        #1;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
    endtask

    // Latency counted so that a result visible right after the accepting edge is 1.
    task automatic wait_result(input int sel, input int exp_lat, input string name);
        int lat;
        logic rdy_seen;
        lat      = 1;
        rdy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((sel == 1) ? out_valid1 : out_valid4) break;
            if ((sel == 1) ? in_ready1 : in_ready4) rdy_seen = 1'b1;
            @(posedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_ready_low_in_norm"}, 32'(rdy_seen), 32'd0);
    endtask

    task automatic run(input int sel, input logic [15:0] d, input res_t e, input int lat,
                       input string name);
        send(sel, d, e);
        wait_result(sel, lat, name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1);
    end

    initial begin
        logic seen;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({out_valid1, out_sign1, out_exp1, out_mant1, out_class1}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1;

        // Normals, specials and subnormals, one at a time.
        run(1, 16'h3B20, '{1'b0, 9'h1F7, 8'hA0, 3'd2}, 1, "n3b20");
        run(1, 16'hA010, '{1'b1, 9'h1C1, 8'h90, 3'd2}, 1, "na010");
        run(1, 16'h3F80, '{1'b0, 9'h000, 8'h80, 3'd2}, 1, "n3f80");
        run(1, 16'h7F7F, '{1'b0, 9'h07F, 8'hFF, 3'd2}, 1, "n7f7f");
        run(1, 16'h0080, '{1'b0, 9'h182, 8'h80, 3'd2}, 1, "n0080");
        run(1, 16'h0001, '{1'b0, 9'h17B, 8'h80, 3'd1}, 8, "s0001");
        run(1, 16'h0040, '{1'b0, 9'h181, 8'h80, 3'd1}, 2, "s0040");
        run(1, 16'h807F, '{1'b1, 9'h181, 8'hFE, 3'd1}, 2, "s807f");
        run(4, 16'h0012, '{1'b0, 9'h17F, 8'h90, 3'd1}, 2, "s0012_x4");
        run(4, 16'h0001, '{1'b0, 9'h17B, 8'h80, 3'd1}, 3, "s0001_x4");

        // Back-to-back specials with the sink stalled for three cycles.
        pop_cyc.delete();
        out_ready = 1'b0;
        send(1, 16'h7F80, '{1'b0, 9'h080, 8'h80, 3'd3});
        repeat (3) begin
            @(negedge clk);
            check("stall_hold",
                  32'({out_valid1, out_sign1, out_exp1, out_mant1, out_class1, in_ready1}),
                  32'({1'b1, 1'b0, 9'h080, 8'h80, 3'd3, 1'b0}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1, 16'h7FC1, '{1'b0, 9'h080, 8'hC1, 3'd4});
        send(1, 16'h8000, '{1'b1, 9'h000, 8'h00, 3'd0});
        repeat (3) @(posedge clk);
        #1;
        check("stream_count", 32'(pop_cyc.size()), 32'd3);
        if (pop_cyc.size() >= 3) begin
            check("stream_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
            check("stream_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
        end

        // Reset in the middle of subnormal normalization drops the operand.
        send(1, 16'h0001, '{1'b0, 9'h17B, 8'h80, 3'd1});
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_norm",
              32'({out_valid1, out_sign1, out_exp1, out_mant1, out_class1}), 32'd0);
        if (q1.size() > 0) void'(q1.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", 32'(in_ready1), 32'd1);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid1) seen = 1'b1;
        end
        check("no_emit_after_reset", 32'(seen), 32'd0);

        repeat (3) @(posedge clk);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
